// File: rtl/ram_burst_ctrl.sv
// Burst controller for a single-port synchronous RAM with 1-cycle read latency.
// Streams write beats into the RAM and read words out through a 2-entry skid buffer.
module ram_burst_ctrl #(
    parameter int unsigned Data_width = 32,
    parameter int unsigned Addr_width = 7,
    parameter int unsigned Len_width  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [Addr_width-1:0] cmd_addr,
    input  logic [Len_width-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [Data_width-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [Data_width-1:0] rd_data,
    output logic                  done,
    output logic                  ram_we,
    output logic [Addr_width-1:0] ram_address,
    output logic [Data_width-1:0] ram_d,
    input  logic [Data_width-1:0] ram_q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [Addr_width-1:0]  addr_q, addr_d;
    logic [Len_width-1:0]   issue_left_q, issue_left_d;
    logic [Len_width-1:0]   deliver_left_q, deliver_left_d;
    logic                   inflight_q, inflight_d;
    logic [Data_width-1:0]  buf_q [2];
    logic                   wptr_q, rptr_q;
    logic [1:0]             count_q;

    logic                   issue_c;
    logic                   push_c;
    logic                   pop_c;
    logic [2:0]             occupancy_c;

    // Next-state, address/length bookkeeping and read issue decision
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        issue_left_d   = issue_left_q;
        deliver_left_d = deliver_left_q;
        inflight_d     = 1'b0;
        issue_c        = 1'b0;
        push_c         = inflight_q;
        pop_c          = (count_q != 2'd0) && rd_ready;
        // Words that will occupy the buffer next cycle if nothing new is issued
        occupancy_c    = 3'(inflight_q) + 3'(count_q) - 3'(pop_c);

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d         = cmd_addr;
                    issue_left_d   = cmd_len;
                    deliver_left_d = cmd_len;
                    if (cmd_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = cmd_write ? WRITE : READ;
                    end
                end
            end
            WRITE: begin
                if (wr_valid) begin
                    addr_d       = addr_q + Addr_width'(1);
                    issue_left_d = issue_left_q - Len_width'(1);
                    if (issue_left_q == Len_width'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                issue_c = (issue_left_q != '0) && (occupancy_c < 3'd2);
                if (issue_c) begin
                    addr_d       = addr_q + Addr_width'(1);
                    issue_left_d = issue_left_q - Len_width'(1);
                end
                if (pop_c) begin
                    deliver_left_d = deliver_left_q - Len_width'(1);
                    if (deliver_left_q == Len_width'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        inflight_d = issue_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            issue_left_q   <= '0;
            deliver_left_q <= '0;
            inflight_q     <= 1'b0;
            wptr_q         <= 1'b0;
            rptr_q         <= 1'b0;
            count_q        <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            issue_left_q   <= issue_left_d;
            deliver_left_q <= deliver_left_d;
            inflight_q     <= inflight_d;
            // RAM output is valid the cycle after its address was issued
            if (push_c) begin
                buf_q[wptr_q] <= ram_q;
                wptr_q        <= ~wptr_q;
            end
            if (pop_c) begin
                rptr_q <= ~rptr_q;
            end
            count_q <= 2'(count_q + 2'(push_c) - 2'(pop_c));
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign wr_ready    = (state_q == WRITE);
    assign ram_we      = (state_q == WRITE) && wr_valid;
    assign ram_d       = (state_q == WRITE) ? wr_data : '0;
    assign ram_address = addr_q;
    assign rd_valid    = (count_q != 2'd0);
    assign rd_data     = buf_q[rptr_q];
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: behavioural RAM, shadow memory and scoreboard queues.
module tb_ram_burst_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 7;
    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          done;
    logic          ram_we;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_d;
    logic [DW-1:0] ram_q = '0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wbeat_t;

    wbeat_t        wq[$];
    logic [DW-1:0] rq[$];
    logic [DW-1:0] shadow [1 << AW];
    logic [DW-1:0] mem    [1 << AW];

    ram_burst_ctrl #(
        .Data_width(DW),
        .Addr_width(AW),
        .Len_width (LW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .done       (done),
        .ram_we     (ram_we),
        .ram_address(ram_address),
        .ram_d      (ram_d),
        .ram_q      (ram_q)
    );

    always #5 clk = ~clk;

    // Write-first synchronous RAM with registered output
    always @(posedge clk) begin
        if (ram_we) mem[ram_address] <= ram_d;
        ram_q <= ram_we ? ram_d : mem[ram_address];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called at a falling edge; offers one command for a single cycle
    task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] len,
                            output bit rdy);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = len;
        #1;
        rdy = cmd_ready;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_cmp++; if (rd_data !== '0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
        n_cmp++; if (ram_address !== '0) begin n_err++; $display("FAIL reset_ram_address: got %h want 0", ram_address); end
        n_cmp++; if (ram_d !== '0) begin n_err++; $display("FAIL reset_ram_d: got %h want 0", ram_d); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_burst(input logic [AW-1:0] a, input int len,
                                    input logic [DW-1:0] base, input bit stall);
        bit     rdy;
        bit     got_done = 1'b0;
        int     beats = 0;
        int     cyc = 0;
        int     last_beat = -1;
        wbeat_t e;
        wq.delete();
        for (int i = 0; i < len; i++) begin
            e.a = AW'(int'(a) + i);
            e.d = base + DW'(i);
            wq.push_back(e);
            shadow[e.a] = e.d;
        end
        send_cmd(1'b1, a, LW'(len), rdy);
        n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL wr_cmd_ready: got %b want 1", rdy); end
        while (!got_done && cyc < 300) begin
            wr_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_data  = base + DW'(beats);
            #1;
            if (done) begin
                got_done = 1'b1;
                n_cmp++; if (wq.size() != 0) begin n_err++; $display("FAIL wr_beats_left: got %0d want 0", wq.size()); end
                n_cmp++; if (last_beat != cyc - 1) begin n_err++; $display("FAIL wr_done_timing: got cycle %0d want %0d", cyc, last_beat + 1); end
                n_cmp++; if (ram_we !== 1'b0 || wr_ready !== 1'b0) begin n_err++; $display("FAIL wr_done_quiet: got we=%b rdy=%b want 0 0", ram_we, wr_ready); end
            end else begin
                n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready: got %b want 1", wr_ready); end
                n_cmp++; if (ram_we !== wr_valid) begin n_err++; $display("FAIL wr_ram_we: got %b want %b", ram_we, wr_valid); end
                if (ram_we === 1'b1) begin
                    n_cmp++;
                    if (wq.size() == 0) begin
                        n_err++; $display("FAIL wr_extra_beat: got beat at %h want none", ram_address);
                    end else begin
                        e = wq.pop_front();
                        if (ram_address !== e.a || ram_d !== e.d) begin
                            n_err++; $display("FAIL wr_beat: got %h:%h want %h:%h", ram_address, ram_d, e.a, e.d);
                        end
                    end
                    beats++;
                    last_beat = cyc;
                end
            end
            @(negedge clk);
            cyc++;
        end
        wr_valid = 1'b0;
        n_cmp++; if (!got_done) begin n_err++; $display("FAIL wr_timeout: got no done want done"); end
        #1;
        n_cmp++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL wr_after_done: got rdy=%b done=%b want 1 0", cmd_ready, done); end
        @(negedge clk);
    endtask

    task automatic test_read_burst(input logic [AW-1:0] a, input int len, input bit pattern);
        bit            rdy;
        bit            got_done = 1'b0;
        bit            prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic [DW-1:0] exp_d;
        int            cyc = 1;
        int            first_valid = -1;
        int            last_hs = -1;
        int            hs = 0;
        int            issued;
        rq.delete();
        for (int i = 0; i < len; i++) rq.push_back(shadow[AW'(int'(a) + i)]);
        send_cmd(1'b0, a, LW'(len), rdy);
        n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL rd_cmd_ready: got %b want 1", rdy); end
        while (!got_done && cyc < 400) begin
            rd_ready  = pattern ? ((cyc - 1) % 3 == 0) : 1'b1;
            cmd_valid = pattern;
            cmd_write = 1'b1;
            cmd_len   = 8'd1;
            #1;
            if (done) begin
                got_done  = 1'b1;
                cmd_valid = 1'b0;
                n_cmp++; if (rq.size() != 0) begin n_err++; $display("FAIL rd_words_left: got %0d want 0", rq.size()); end
                n_cmp++; if (last_hs != cyc - 1) begin n_err++; $display("FAIL rd_done_timing: got cycle %0d want %0d", cyc, last_hs + 1); end
                n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rd_done_valid: got %b want 0", rd_valid); end
            end else begin
                n_cmp++; if (cmd_ready !== 1'b0 || ram_we !== 1'b0) begin n_err++; $display("FAIL rd_busy: got rdy=%b we=%b want 0 0", cmd_ready, ram_we); end
                issued = int'(AW'(ram_address - a));
                n_cmp++; if (issued - hs > 2) begin n_err++; $display("FAIL rd_outstanding: got %0d want <=2", issued - hs); end
                if (prev_stall) begin
                    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== prev_data) begin n_err++; $display("FAIL rd_stable: got %b:%h want 1:%h", rd_valid, rd_data, prev_data); end
                end
                if (rd_valid === 1'b1 && first_valid < 0) first_valid = cyc;
                if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
                    n_cmp++;
                    if (rq.size() == 0) begin
                        n_err++; $display("FAIL rd_extra_word: got %h want none", rd_data);
                    end else begin
                        exp_d = rq.pop_front();
                        if (rd_data !== exp_d) begin n_err++; $display("FAIL rd_data: got %h want %h", rd_data, exp_d); end
                    end
                    hs++;
                    last_hs = cyc;
                end
                prev_stall = (rd_valid === 1'b1) && (rd_ready !== 1'b1);
                prev_data  = rd_data;
            end
            @(negedge clk);
            cyc++;
        end
        rd_ready  = 1'b0;
        cmd_valid = 1'b0;
        n_cmp++; if (!got_done) begin n_err++; $display("FAIL rd_timeout: got no done want done"); end
        if (!pattern) begin
            n_cmp++; if (first_valid != 3) begin n_err++; $display("FAIL rd_first_latency: got %0d want 3", first_valid); end
            n_cmp++; if (last_hs != first_valid + len - 1) begin n_err++; $display("FAIL rd_streaming: got last %0d want %0d", last_hs, first_valid + len - 1); end
        end
        #1;
        n_cmp++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL rd_after_done: got rdy=%b done=%b want 1 0", cmd_ready, done); end
        @(negedge clk);
    endtask

    task automatic test_zero_len(input bit wr);
        bit rdy;
        send_cmd(wr, 7'h05, 8'd0, rdy);
        n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL zl_cmd_ready: got %b want 1", rdy); end
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        #1;
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL zl_done: got %b want 1", done); end
        n_cmp++; if (wr_ready !== 1'b0 || ram_we !== 1'b0 || rd_valid !== 1'b0) begin n_err++; $display("FAIL zl_quiet: got wrdy=%b we=%b rv=%b want 0 0 0", wr_ready, ram_we, rd_valid); end
        @(negedge clk);
        #1;
        n_cmp++; if (done !== 1'b0 || cmd_ready !== 1'b1 || ram_we !== 1'b0) begin n_err++; $display("FAIL zl_after: got done=%b rdy=%b we=%b want 0 1 0", done, cmd_ready, ram_we); end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        bit            rdy;
        int            hs = 0;
        int            cyc = 0;
        logic [DW-1:0] exp_d;
        rq.delete();
        for (int i = 0; i < 6; i++) rq.push_back(shadow[AW'(7'h40 + i)]);
        send_cmd(1'b0, 7'h40, 8'd6, rdy);
        n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 1", rdy); end
        rd_ready = 1'b1;
        while (hs < 2 && cyc < 50) begin
            #1;
            if (rd_valid === 1'b1) begin
                exp_d = rq.pop_front();
                n_cmp++; if (rd_data !== exp_d) begin n_err++; $display("FAIL rst_pre_data: got %h want %h", rd_data, exp_d); end
                hs++;
            end
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (hs != 2) begin n_err++; $display("FAIL rst_pre_count: got %0d want 2", hs); end
        reset = 1'b1;
        #1;
        n_cmp++; if (rd_valid !== 1'b0 || done !== 1'b0 || ram_we !== 1'b0) begin n_err++; $display("FAIL rst_immediate: got rv=%b done=%b we=%b want 0 0 0", rd_valid, done, ram_we); end
        n_cmp++; if (cmd_ready !== 1'b1 || rd_data !== '0) begin n_err++; $display("FAIL rst_values: got rdy=%b rd=%h want 1 0", cmd_ready, rd_data); end
        @(negedge clk);
        reset    = 1'b0;
        rd_ready = 1'b0;
        rq.delete();
        @(negedge clk);
        #1;
        n_cmp++; if (cmd_ready !== 1'b1 || rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_release: got rdy=%b rv=%b want 1 0", cmd_ready, rd_valid); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_burst(7'h10, 4, 32'hA0, 1'b0);
        test_read_burst(7'h10, 4, 1'b0);
        test_write_burst(7'h20, 8, 32'h100, 1'b0);
        test_read_burst(7'h20, 8, 1'b1);
        test_write_burst(7'h7E, 4, 32'h1, 1'b0);
        test_read_burst(7'h7E, 4, 1'b0);
        test_zero_len(1'b1);
        test_zero_len(1'b0);
        test_write_burst(7'h30, 5, 32'h500, 1'b1);
        test_read_burst(7'h30, 5, 1'b1);
        test_write_burst(7'h40, 6, 32'h300, 1'b0);
        test_reset_mid_read();
        test_read_burst(7'h40, 2, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
- Initiator-side burst controller for the team's single-port 128x32 synchronous RAM (registered read output, 1-cycle read latency, write-first port).
- Accepts burst read/write commands on a valid/ready command channel.
- Streams write data in and read data out on valid/ready channels with full backpressure.
- Drives the RAM's we/address/d pins and consumes its q.

Parameters:
- Data_width, 32, bits per word.
- Addr_width, 7, RAM address bits (depth 2**Addr_width).
- Len_width, 8, bits of burst length field.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_addr  in  Addr_width  start address
- cmd_len  in  Len_width  word count (0 legal)
- wr_valid  in  1  write word offered
- wr_ready  out  1  write word accepted
- wr_data  in  Data_width  write word
- rd_valid  out  1  read word offered
- rd_ready  in  1  read word accepted
- rd_data  out  Data_width  read word
- done  out  1  one-cycle pulse, burst complete
- ram_we  out  1  RAM write enable
- ram_address  out  Addr_width  RAM address
- ram_d  out  Data_width  RAM write data
- ram_q  in  Data_width  RAM read data (valid the cycle after its address)

Behaviour:
- Reset values: state IDLE; cmd_ready=1; wr_ready=0; rd_valid=0; rd_data=0; done=0; ram_we=0; ram_address=0; ram_d=0.
- All registers clear on reset assertion, without waiting for clk; read buffer emptied; no pending work retained.
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch addr, len and direction.
  - len==0 -> DONE; else cmd_write ? WRITE : READ.
  - cmd_ready=0 in all other states.
- WRITE:
  - wr_ready=1.
  - ram_we = wr_valid (combinational); ram_address = current address; ram_d = wr_data.
  - Each accepted beat: address+1 mod 2**Addr_width, remaining-1.
  - Last beat -> DONE.
  - No timeout; stalls indefinitely while wr_valid=0.
- READ:
  - ram_we=0 always.
  - Read issue: present the current address on ram_address, counted as in_flight for one cycle. The word is captured from ram_q on the following edge into a 2-entry FIFO buffer.
  - Issue rule: issue only while words remain unissued and (in_flight + buf_count - pop_this_cycle) < 2. This guarantees no overflow and gives 1 word/cycle when rd_ready is held 1.
  - rd_valid = buffer non-empty (registered); rd_data = buffer head.
  - rd_data and rd_valid stay stable while rd_valid & !rd_ready.
  - After the last word's rd handshake -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- Latency:
  - Command accepted at edge E0; READ occupies the cycle after E0 and presents the first address.
  - rd_valid first asserts 2 cycles later, i.e. the 3rd cycle after E0.
  - done is high in the cycle after the final data handshake.
- Address wrap: 2**Addr_width-1 -> 0. Bursts longer than depth wrap and revisit addresses; legal.
- wr_ready=0 outside WRITE; wr_data ignored. rd_valid=0 outside READ.
- Reset mid-burst:
  - Burst abandoned; outputs return to reset values immediately.
  - RAM words already written stay written.
  - Next command after reset release behaves normally.
- cmd_valid while busy: ignored (held off by cmd_ready=0).

Test Plan:
- Reset, write burst addr=0x10 len=4, wr_valid held 1, data 0xA0..0xA3 -> ram_we high 4 consecutive cycles, ram_address 0x10..0x13, ram_d 0xA0..0xA3, done pulse 1 cycle after last beat, cmd_ready back to 1 next cycle.
- Read burst addr=0x10 len=4, rd_ready held 1 -> rd_valid first in 3rd cycle after accept, rd_data 0xA0,0xA1,0xA2,0xA3 on 4 consecutive cycles, then done pulse.
- Write 8 words 0x100..0x107 at 0x20, then read len=8 with rd_ready pattern 1,0,0 repeating -> all 8 words in order, no loss/duplication, rd_data stable during stalls, at most 2 words outstanding.
- Write addr=0x7E len=4 data 1..4 -> ram_address 0x7E,0x7F,0x00,0x01; read back addr=0x7E len=4 -> 1,2,3,4.
- cmd_len=0 (read and write) -> done pulse in cycle after accept, ram_we never 1, rd_valid never 1, wr_ready never 1.
- Assert reset after 2 of 6 read words delivered -> rd_valid/done/ram_we 0 immediately, cmd_ready=1 after release, following read len=2 returns correct data.
